canny_accel_mul_pipe_vld: RTL and testbench

// - Parametrised, pipelined A x B multiplier with valid/ready flow control for the canny_accel datapath.
// - Next generation of the fixed 16x7 four-stage DSP multiplier. Adds:

---
 rtl/canny_accel_mul_pipe_vld.sv | 172 +++++++++++++++++
 tb/tb_canny_accel_mul_pipe_vld.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_accel_mul_pipe_vld.sv
// Pipelined A x B multiplier with valid/ready flow control.
// Stage 1 registers the operands, stages 2..NUM_STAGE-1 carry the product
// (registered once, then delayed), and the last stage registers the
// rounded, shifted and saturated/truncated result together with ovf.
// A single global stall (adv) freezes every stage while the output is held.
// NUM_STAGE must lie in 3..8 and DOUT_W must be at least 2.
module canny_accel_mul_pipe_vld #(
    parameter int A_W       = 16,
    parameter int B_W       = 7,
    parameter int DOUT_W    = 23,
    parameter int NUM_STAGE = 4,
    parameter int SIGNED    = 0,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int SAT       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [A_W-1:0]    din0,
    input  logic [B_W-1:0]    din1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] dout,
    output logic              ovf
);

    localparam int PW = A_W + B_W;
    // One extra bit so the rounding add can never wrap.
    localparam int RW = PW + 1;
    localparam logic [RW-1:0] RND_C =
        (ROUND != 0 && SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic              adv;
    logic              accept;
    logic              rdy_en_reg;
    logic [A_W-1:0]    a_reg;
    logic [B_W-1:0]    b_reg;
    logic              vld_reg  [1:NUM_STAGE-1];
    logic [PW-1:0]     prod_reg [2:NUM_STAGE-1];
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [RW-1:0]     p_ext;
    logic [RW-1:0]     sum;
    logic [RW-1:0]     fill;
    logic [RW-1:0]     r;
    logic [DOUT_W-1:0] res_next;
    logic              ovf_next;
    logic              out_valid_reg;
    logic              ovf_reg;
    logic [DOUT_W-1:0] dout_reg;

    // Global stall: the whole pipe moves only when the output slot is free or being taken.
    assign adv      = ~out_valid_reg | out_ready;
    assign in_ready = adv & ~flush & rdy_en_reg;
    assign accept   = in_valid & in_ready;

    assign out_valid = out_valid_reg;
    assign dout      = dout_reg;
    assign ovf       = ovf_reg;

    // Holds in_ready low until the first clock edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdy_en_reg <= 1'b0;
        else       rdy_en_reg <= 1'b1;
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_reg[1] <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
        end else if (flush) begin
            vld_reg[1] <= 1'b0;
        end else if (adv) begin
            vld_reg[1] <= accept;
            a_reg      <= din0;
            b_reg      <= din1;
        end
    end

    // Operands widened to the product width; a PW x PW multiply kept to PW bits
    // gives the correct product for both signed and unsigned operands.
    always_comb begin
        a_ext = {{B_W{(SIGNED != 0) & a_reg[A_W-1]}}, a_reg};
        b_ext = {{A_W{(SIGNED != 0) & b_reg[B_W-1]}}, b_reg};
    end

    // Stage 2: registered product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_reg[2]  <= 1'b0;
            prod_reg[2] <= '0;
        end else if (flush) begin
            vld_reg[2]  <= 1'b0;
        end else if (adv) begin
            vld_reg[2]  <= vld_reg[1];
            prod_reg[2] <= a_ext * b_ext;
        end
    end

    // Stages 3..NUM_STAGE-1: extra product registers so the multiplier can be retimed into the DSP.
    for (genvar gi = 3; gi <= NUM_STAGE - 1; gi++) begin : g_dly
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_reg[gi]  <= 1'b0;
                prod_reg[gi] <= '0;
            end else if (flush) begin
                vld_reg[gi]  <= 1'b0;
            end else if (adv) begin
                vld_reg[gi]  <= vld_reg[gi-1];
                prod_reg[gi] <= prod_reg[gi-1];
            end
        end
    end

    // Round and arithmetic right shift in RW bits.
    always_comb begin
        p_ext = {(SIGNED != 0) & prod_reg[NUM_STAGE-1][PW-1], prod_reg[NUM_STAGE-1]};
        sum   = p_ext + RND_C;
        fill  = {RW{(SIGNED != 0) & sum[RW-1]}};
        r     = RW'({fill, sum} >> SHIFT);
    end

    if (DOUT_W >= RW) begin : g_wide
        // Result always fits: extend it, never flag overflow.
        always_comb begin
            res_next         = {DOUT_W{(SIGNED != 0) & r[RW-1]}};
            res_next[RW-1:0] = r;
            ovf_next         = 1'b0;
        end
    end else begin : g_narrow
        localparam logic [DOUT_W-1:0] S_MAX = {DOUT_W{1'b1}} >> 1;
        localparam logic [DOUT_W-1:0] S_MIN = ~S_MAX;
        localparam logic [DOUT_W-1:0] U_MAX = {DOUT_W{1'b1}};
        logic fits;
        logic [DOUT_W-1:0] clamp_val;
        // Fits when the discarded upper bits are a pure sign (or zero) extension.
        always_comb begin
            if (SIGNED != 0) begin
                fits      = (&r[RW-1:DOUT_W-1]) | ~(|r[RW-1:DOUT_W-1]);
                clamp_val = r[RW-1] ? S_MIN : S_MAX;
            end else begin
                fits      = ~(|r[RW-1:DOUT_W]);
                clamp_val = U_MAX;
            end
            res_next = (fits || SAT == 0) ? r[DOUT_W-1:0] : clamp_val;
            ovf_next = ~fits;
        end
    end

    // Output stage: data only updates on a valid beat, so bubbles leave dout unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
            ovf_reg       <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= vld_reg[NUM_STAGE-1];
            if (vld_reg[NUM_STAGE-1]) begin
                dout_reg <= res_next;
                ovf_reg  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_canny_accel_mul_pipe_vld.sv
// Bench for canny_accel_mul_pipe_vld: four configurations share one stimulus
// stream; each has its own scoreboard fed from a plain-arithmetic reference.
module tb_canny_accel_mul_pipe_vld;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] din0;
    logic [6:0]  din1;
    logic [3:0]  in_ready_w, out_valid_w, ovf_w;
    logic [22:0] dout0;
    logic [15:0] dout1;
    logic [22:0] dout2;
    logic [11:0] dout3;
    logic [31:0] dq [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Configuration of each instance, as used by the reference model.
    int c_sg  [4] = '{0, 1, 0, 1};
    int c_dw  [4] = '{23, 16, 23, 12};
    int c_sh  [4] = '{0, 0, 4, 4};
    int c_rd  [4] = '{0, 0, 0, 1};
    int c_sat [4] = '{0, 1, 0, 0};
    int c_lat [4] = '{4, 4, 4, 6};

    always #5 clk = ~clk;

    canny_accel_mul_pipe_vld u0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .din0(din0), .din1(din1), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .dout(dout0), .ovf(ovf_w[0]));

    canny_accel_mul_pipe_vld #(.DOUT_W(16), .SIGNED(1), .SAT(1)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .din0(din0), .din1(din1), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .dout(dout1), .ovf(ovf_w[1]));

    canny_accel_mul_pipe_vld #(.SHIFT(4)) u2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .din0(din0), .din1(din1), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .dout(dout2), .ovf(ovf_w[2]));

    canny_accel_mul_pipe_vld #(.DOUT_W(12), .NUM_STAGE(6), .SIGNED(1), .SHIFT(4), .ROUND(1)) u3 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[3]),
        .din0(din0), .din1(din1), .out_valid(out_valid_w[3]), .out_ready(1'b1),
        .dout(dout3), .ovf(ovf_w[3]));

    assign dq[0] = 32'(dout0);
    assign dq[1] = 32'(dout1);
    assign dq[2] = 32'(dout2);
    assign dq[3] = 32'(dout3);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer product, optional half-LSB rounding, floor shift, then range check.
    function automatic logic [32:0] ref_calc(input longint a, input longint b, input int k);
        longint av, bv, p, r, lo, hi, v;
        logic   o;
        av = (c_sg[k] != 0 && a >= 32768) ? a - 65536 : a;
        bv = (c_sg[k] != 0 && b >= 64) ? b - 128 : b;
        p  = av * bv;
        if (c_rd[k] != 0 && c_sh[k] > 0) p = p + (longint'(1) << (c_sh[k] - 1));
        r  = p >>> c_sh[k];
        if (c_sg[k] != 0) begin
            lo = -(longint'(1) << (c_dw[k] - 1));
            hi = (longint'(1) << (c_dw[k] - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << c_dw[k]) - 1;
        end
        o = (r < lo) || (r > hi);
        v = r;
        if (o && c_sat[k] != 0) v = (r < lo) ? lo : hi;
        v = v & ((longint'(1) << c_dw[k]) - 1);
        return {o, v[31:0]};
    endfunction

    // Scoreboards: circular buffers per instance.
    logic [32:0] exp_mem [4][256];
    int          exp_cyc [4][256];
    int          exp_stl [4][256];
    int          wr_p [4] = '{0, 0, 0, 0};
    int          rd_p [4] = '{0, 0, 0, 0};
    int          cyc = 0;
    int          stall_cnt = 0;
    logic        rdy_m = 1'b0;

    // Cycle count and the expected post-reset ready enable.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_m <= !reset;
    end

    // Monitor: handshakes are taken at the following rising edge, so sample on the falling edge.
    always @(negedge clk) begin
        logic [32:0] e;
        logic        or_i;
        logic        exp_ir;
        int          idx;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rd_p[i] = wr_p[i];
                chk($sformatf("d%0d_rst_vld", i), out_valid_w[i], 1'b0);
                chk($sformatf("d%0d_rst_dout", i), dq[i], 32'd0);
                chk($sformatf("d%0d_rst_ovf", i), ovf_w[i], 1'b0);
                chk($sformatf("d%0d_rst_rdy", i), in_ready_w[i], 1'b0);
            end
        end else begin
            if (!out_ready) stall_cnt++;
            for (int i = 0; i < 4; i++) begin
                or_i   = (i == 3) ? 1'b1 : out_ready;
                exp_ir = rdy_m & ~flush & (~out_valid_w[i] | or_i);
                chk($sformatf("d%0d_in_ready", i), in_ready_w[i], exp_ir);
                if (out_valid_w[i]) begin
                    chk($sformatf("d%0d_vld_pending", i), out_valid_w[i], wr_p[i] != rd_p[i]);
                    if (or_i && wr_p[i] != rd_p[i]) begin
                        idx = rd_p[i] & 255;
                        e   = exp_mem[i][idx];
                        chk($sformatf("d%0d_dout", i), dq[i], e[31:0]);
                        chk($sformatf("d%0d_ovf", i), ovf_w[i], e[32]);
                        if (i == 3 || exp_stl[i][idx] == stall_cnt)
                            chk($sformatf("d%0d_latency", i), cyc - exp_cyc[i][idx], c_lat[i]);
                        if (i == 0)
                            $display("[TB] d0 out cyc=%0d dout=%0d ovf=%0d", cyc, dq[0], ovf_w[0]);
                        rd_p[i]++;
                    end
                end
                if (in_valid && in_ready_w[i]) begin
                    idx = wr_p[i] & 255;
                    exp_mem[i][idx] = ref_calc(longint'(din0), longint'(din1), i);
                    exp_cyc[i][idx] = cyc;
                    exp_stl[i][idx] = stall_cnt;
                    wr_p[i]++;
                end
            end
            if (flush)
                for (int i = 0; i < 4; i++) rd_p[i] = wr_p[i];
        end
    end

    function automatic logic [15:0] pick_a();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [6:0] pick_b();
        case ($urandom_range(0, 5))
            0:       return 7'h00;
            1:       return 7'h7F;
            2:       return 7'h40;
            3:       return 7'h3F;
            default: return 7'($urandom);
        endcase
    endfunction

    // Single isolated operation with a known answer on instance k, checked at exact latency.
    task automatic ka(input logic [15:0] a, input logic [6:0] b, input int k,
                      input longint ed, input logic eo);
        flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; din0 = a; din1 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (c_lat[k] - 2) @(posedge clk);
        #1;
        chk($sformatf("ka_d%0d_early_vld", k), out_valid_w[k], 1'b0);
        @(posedge clk); #1;
        chk($sformatf("ka_d%0d_vld", k), out_valid_w[k], 1'b1);
        chk($sformatf("ka_d%0d_dout", k), dq[k], ed[31:0]);
        chk($sformatf("ka_d%0d_ovf", k), ovf_w[k], eo);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back, 1: 6-cycle stall window, 2: random valid/ready/flush.
    task automatic run_stream(input int n, input int mode);
        logic acc;
        acc = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (!in_valid || acc) begin
                din0 = pick_a();
                din1 = pick_b();
            end
            case (mode)
                0: begin in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; end
                1: begin in_valid = 1'b1; out_ready = !(k >= 10 && k < 16); flush = 1'b0; end
                default: begin
                    in_valid  = ($urandom_range(0, 99) < 75);
                    out_ready = ($urandom_range(0, 99) < 70);
                    flush     = ($urandom_range(0, 99) < 3);
                end
            endcase
            @(negedge clk);
            acc = in_valid & in_ready_w[0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        din0 = '0; din1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        ka(16'hFFFF, 7'h7F, 0, 8322945, 1'b0);
        ka(16'h8000, 7'h40, 1, 32767, 1'b1);
        ka(16'h8000, 7'h3F, 1, 32768, 1'b1);
        ka(16'd100, 7'd3, 2, 18, 1'b0);
        ka(16'd100, 7'd3, 3, 19, 1'b0);
        ka(16'd8, 7'd1, 3, 1, 1'b0);

        run_stream(20, 0);
        idle(10);
        run_stream(30, 1);
        idle(10);
        run_stream(400, 2);
        idle(12);

        // Flush with three operations in flight, input offered during the flush.
        run_stream(3, 0);
        flush = 1'b1; in_valid = 1'b1; din0 = 16'd999; din1 = 7'd9;
        @(posedge clk); #1;
        idle(8);
        ka(16'd123, 7'd45, 0, 5535, 1'b0);

        // Reset asserted mid-cycle with three operations in flight.
        run_stream(3, 0);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        idle(6);
        ka(16'd1000, 7'd100, 0, 100000, 1'b0);

        idle(12);
        for (int i = 0; i < 4; i++)
            chk($sformatf("d%0d_drain", i), wr_p[i] - rd_p[i], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
